// File: rtl/trap_seq_ctrl.sv
// trap_seq_ctrl
//   Trap and WFI sequencer between the exception/interrupt unit and the pipeline.
//   - Turns a trap_req level into a held flush_req/flush_ack handshake toward the IFU,
//     with a stable flush_pc and a one-cycle trap_cmt strobe that gates CSR updates.
//   - Turns a committed WFI into a halt-IFU/halt-EXU handshake, a SLEEP state and an
//     interrupt-driven wakeup, counting cycles spent asleep.
//
// Build option:
//   TRAP_SEQ_WFI_EN  defined   -> full WFI sequencing (HALT/SLEEP states).
//                    undefined -> wfi_req ignored; halt_*_req, core_wfi, sleep_cnt tied 0.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   trap_req, trap_pc               trap flush request (level) and its target PC
//   wfi_req                         one-cycle pulse: WFI committed
//   ext/sft/tmr_irq_r, meie/msie/mtie_r  pending interrupts and per-source enables
//   flush_req, flush_ack, flush_pc  flush handshake toward the IFU
//   trap_cmt                        one-cycle pulse when the flush handshake completes
//   halt_ifu_req/ack, halt_exu_req/ack  halt handshakes
//   core_wfi                        core asleep (clock-gate hint)
//   sleep_cnt                       saturating count of cycles spent in SLEEP

module trap_seq_ctrl #(
    parameter int unsigned PC_W  = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             trap_req,
    input  logic [PC_W-1:0]  trap_pc,
    input  logic             wfi_req,
    input  logic             ext_irq_r,
    input  logic             sft_irq_r,
    input  logic             tmr_irq_r,
    input  logic             meie_r,
    input  logic             msie_r,
    input  logic             mtie_r,
    output logic             flush_req,
    input  logic             flush_ack,
    output logic [PC_W-1:0]  flush_pc,
    output logic             trap_cmt,
    output logic             halt_ifu_req,
    output logic             halt_exu_req,
    input  logic             halt_ifu_ack,
    input  logic             halt_exu_ack,
    output logic             core_wfi,
    output logic [CNT_W-1:0] sleep_cnt
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFlush = 2'd1,
        StHalt  = 2'd2,
        StSleep = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [PC_W-1:0] flush_pc_q, flush_pc_d;

`ifdef TRAP_SEQ_WFI_EN
    logic             ifu_ack_q, ifu_ack_d;
    logic             exu_ack_q, exu_ack_d;
    logic [CNT_W-1:0] sleep_cnt_q, sleep_cnt_d;
    logic             irq_pend;
    logic             ifu_ack_seen, exu_ack_seen;

    // mstatus.MIE is deliberately not consulted: WFI wakes on any enabled pending source.
    assign irq_pend = (ext_irq_r & meie_r) | (sft_irq_r & msie_r) | (tmr_irq_r & mtie_r);
    assign ifu_ack_seen = ifu_ack_q | halt_ifu_ack;
    assign exu_ack_seen = exu_ack_q | halt_exu_ack;
`else
    logic unused_wfi_inputs;
    assign unused_wfi_inputs = ^{wfi_req, ext_irq_r, sft_irq_r, tmr_irq_r, meie_r, msie_r,
                                 mtie_r, halt_ifu_ack, halt_exu_ack};
`endif

    always_comb begin
        state_d    = state_q;
        flush_pc_d = flush_pc_q;
        trap_cmt   = 1'b0;
        case (state_q)
            StIdle: begin
                if (trap_req) begin
                    state_d    = StFlush;
                    flush_pc_d = trap_pc;
                end
`ifdef TRAP_SEQ_WFI_EN
                else if (wfi_req) begin
                    state_d = StHalt;
                end
`endif
            end
            StFlush: begin
                if (flush_ack) begin
                    trap_cmt = 1'b1;
                    // A trap_req still high at completion is a new trap: re-enter directly.
                    if (trap_req) begin
                        flush_pc_d = trap_pc;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
`ifdef TRAP_SEQ_WFI_EN
            StHalt: begin
                if (trap_req) begin
                    state_d    = StFlush;
                    flush_pc_d = trap_pc;
                end else if (irq_pend) begin
                    state_d = StIdle;
                end else if (ifu_ack_seen && exu_ack_seen) begin
                    state_d = StSleep;
                end
            end
            StSleep: begin
                if (trap_req) begin
                    state_d    = StFlush;
                    flush_pc_d = trap_pc;
                end else if (irq_pend) begin
                    state_d = StIdle;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

`ifdef TRAP_SEQ_WFI_EN
    always_comb begin
        // Sticky acks live only for the duration of one HALT visit.
        ifu_ack_d   = 1'b0;
        exu_ack_d   = 1'b0;
        sleep_cnt_d = sleep_cnt_q;
        if (state_q == StHalt && state_d == StHalt) begin
            ifu_ack_d = ifu_ack_seen;
            exu_ack_d = exu_ack_seen;
        end
        if (state_q == StSleep && sleep_cnt_q != {CNT_W{1'b1}}) begin
            sleep_cnt_d = sleep_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifu_ack_q   <= 1'b0;
            exu_ack_q   <= 1'b0;
            sleep_cnt_q <= '0;
        end else begin
            ifu_ack_q   <= ifu_ack_d;
            exu_ack_q   <= exu_ack_d;
            sleep_cnt_q <= sleep_cnt_d;
        end
    end

    assign halt_ifu_req = (state_q == StHalt) || (state_q == StSleep);
    assign halt_exu_req = halt_ifu_req;
    assign core_wfi     = (state_q == StSleep);
    assign sleep_cnt    = sleep_cnt_q;
`else
    assign halt_ifu_req = 1'b0;
    assign halt_exu_req = 1'b0;
    assign core_wfi     = 1'b0;
    assign sleep_cnt    = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            flush_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            flush_pc_q <= flush_pc_d;
        end
    end

    assign flush_req = (state_q == StFlush);
    assign flush_pc  = flush_pc_q;

endmodule

// File: tb/tb_trap_seq_ctrl.sv
// Self-checking bench for trap_seq_ctrl. Inputs change on the falling edge; outputs are
// sampled shortly after the falling edge, well away from the rising (active) edge.
// Expected flush targets / sleep counts are queued when stimulus is applied and popped
// when the DUT signals completion (trap_cmt / wake).

module tb_trap_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        trap_req;
    logic [31:0] trap_pc;
    logic        wfi_req;
    logic        ext_irq_r, sft_irq_r, tmr_irq_r;
    logic        meie_r, msie_r, mtie_r;
    logic        flush_req;
    logic        flush_ack;
    logic [31:0] flush_pc;
    logic        trap_cmt;
    logic        halt_ifu_req, halt_exu_req;
    logic        halt_ifu_ack, halt_exu_ack;
    logic        core_wfi;
    logic [31:0] sleep_cnt;

    int          errs;
    int          checks;
    logic [31:0] exp_q[$];
    logic [31:0] exp_val;

    trap_seq_ctrl #(
        .PC_W (32),
        .CNT_W(32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .trap_req    (trap_req),
        .trap_pc     (trap_pc),
        .wfi_req     (wfi_req),
        .ext_irq_r   (ext_irq_r),
        .sft_irq_r   (sft_irq_r),
        .tmr_irq_r   (tmr_irq_r),
        .meie_r      (meie_r),
        .msie_r      (msie_r),
        .mtie_r      (mtie_r),
        .flush_req   (flush_req),
        .flush_ack   (flush_ack),
        .flush_pc    (flush_pc),
        .trap_cmt    (trap_cmt),
        .halt_ifu_req(halt_ifu_req),
        .halt_exu_req(halt_exu_req),
        .halt_ifu_ack(halt_ifu_ack),
        .halt_exu_ack(halt_exu_ack),
        .core_wfi    (core_wfi),
        .sleep_cnt   (sleep_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        trap_req = 0; trap_pc = 0; wfi_req = 0; flush_ack = 0;
        ext_irq_r = 0; sft_irq_r = 0; tmr_irq_r = 0; meie_r = 0; msie_r = 0; mtie_r = 0;
        halt_ifu_ack = 0; halt_exu_ack = 0;
        repeat (2) cyc();
        #1;
        checks++;
        if ({flush_req, trap_cmt, halt_ifu_req, halt_exu_req, core_wfi} !== 5'b0 ||
            flush_pc !== 32'h0 || sleep_cnt !== 32'h0) begin
            errs++;
            $display("FAIL reset_outputs: got req=%b cmt=%b hi=%b he=%b wfi=%b pc=%h cnt=%0d, want all 0",
                     flush_req, trap_cmt, halt_ifu_req, halt_exu_req, core_wfi, flush_pc, sleep_cnt);
        end
        cyc();
        rst_n = 1'b1;
    endtask

    // Pop the queued flush target when trap_cmt is seen and compare against flush_pc.
    task automatic pop_flush(input string name);
        checks++;
        if (exp_q.size() == 0) begin
            errs++;
            $display("FAIL %s_pop: trap_cmt with empty scoreboard, flush_pc=%h", name, flush_pc);
        end else begin
            exp_val = exp_q.pop_front();
            if (flush_pc !== exp_val) begin
                errs++;
                $display("FAIL %s_cmt_pc: got %h want %h", name, flush_pc, exp_val);
            end
        end
    endtask

    task automatic test_trap();
        cyc();
        trap_req = 1; trap_pc = 32'h8000_0100; flush_ack = 0;
        exp_q.push_back(32'h8000_0100);
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (i == 3) begin
                flush_ack = 1; trap_req = 0;
            end else begin
                trap_pc = 32'hDEAD_BEEF; // must not be re-sampled during the hold
            end
            #1;
            checks++;
            if (flush_req !== 1'b1 || flush_pc !== 32'h8000_0100 || trap_cmt !== (i == 3)) begin
                errs++;
                $display("FAIL trap_hold[%0d]: got req=%b pc=%h cmt=%b want req=1 pc=80000100 cmt=%b",
                         i, flush_req, flush_pc, trap_cmt, (i == 3));
            end
            if (trap_cmt === 1'b1) pop_flush("trap");
        end
        cyc();
        flush_ack = 0;
        #1;
        checks++;
        if (flush_req !== 1'b0 || trap_cmt !== 1'b0 || exp_q.size() != 0) begin
            errs++;
            $display("FAIL trap_idle: got req=%b cmt=%b pending=%0d want 0 0 0",
                     flush_req, trap_cmt, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        cyc();
        trap_req = 1; trap_pc = 32'h0000_1000; flush_ack = 1;
        exp_q.push_back(32'h0000_1000);
        cyc();
        trap_pc = 32'h0000_2000; // still requesting: a second trap
        exp_q.push_back(32'h0000_2000);
        #1;
        checks++;
        if (trap_cmt !== 1'b1) begin
            errs++;
            $display("FAIL b2b_first_cmt: got %b want 1", trap_cmt);
        end
        if (trap_cmt === 1'b1) pop_flush("b2b_first");
        cyc();
        trap_req = 0;
        #1;
        checks++;
        if (flush_req !== 1'b1 || trap_cmt !== 1'b1) begin
            errs++;
            $display("FAIL b2b_second: got req=%b cmt=%b want 1 1", flush_req, trap_cmt);
        end
        if (trap_cmt === 1'b1) pop_flush("b2b_second");
        cyc();
        flush_ack = 0;
        #1;
        checks++;
        if (flush_req !== 1'b0 || exp_q.size() != 0) begin
            errs++;
            $display("FAIL b2b_idle: got req=%b pending=%0d want 0 0", flush_req, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_simultaneous();
        cyc();
        trap_req = 1; wfi_req = 1; trap_pc = 32'h8000_0200; flush_ack = 0;
        exp_q.push_back(32'h8000_0200);
        cyc();
        wfi_req = 0;
        #1;
        checks++;
        if (flush_req !== 1'b1 || halt_ifu_req !== 1'b0 || halt_exu_req !== 1'b0) begin
            errs++;
            $display("FAIL simul_flush: got req=%b hi=%b he=%b want 1 0 0",
                     flush_req, halt_ifu_req, halt_exu_req);
        end
        cyc();
        flush_ack = 1; trap_req = 0;
        #1;
        checks++;
        if (trap_cmt !== 1'b1 || halt_ifu_req !== 1'b0) begin
            errs++;
            $display("FAIL simul_cmt: got cmt=%b hi=%b want 1 0", trap_cmt, halt_ifu_req);
        end
        if (trap_cmt === 1'b1) pop_flush("simul");
        cyc();
        flush_ack = 0;
        #1;
        checks++;
        if (halt_ifu_req !== 1'b0 || halt_exu_req !== 1'b0 || flush_req !== 1'b0) begin
            errs++;
            $display("FAIL simul_after: got hi=%b he=%b req=%b want 0 0 0 (WFI dropped)",
                     halt_ifu_req, halt_exu_req, flush_req);
        end
        exp_q.delete();
    endtask

`ifdef TRAP_SEQ_WFI_EN
    task automatic test_wfi();
        cyc();
        wfi_req = 1;                           // cycle 0
        cyc();
        wfi_req = 0;                           // cycle 1
        #1;
        checks++;
        if (halt_ifu_req !== 1'b1 || halt_exu_req !== 1'b1 || core_wfi !== 1'b0) begin
            errs++;
            $display("FAIL wfi_halt: got hi=%b he=%b wfi=%b want 1 1 0",
                     halt_ifu_req, halt_exu_req, core_wfi);
        end
        cyc(); halt_ifu_ack = 1;               // cycle 2
        cyc();                                 // cycle 3
        #1;
        checks++;
        if (core_wfi !== 1'b0) begin
            errs++;
            $display("FAIL wfi_wait_exu: got core_wfi=%b want 0", core_wfi);
        end
        cyc(); halt_exu_ack = 1;               // cycle 4
        for (int c = 5; c < 15; c++) begin
            cyc();
            halt_exu_ack = 0;
            #1;
            checks++;
            if (core_wfi !== 1'b1 || halt_ifu_req !== 1'b1 || sleep_cnt !== 32'(c - 5)) begin
                errs++;
                $display("FAIL wfi_sleep[%0d]: got wfi=%b hi=%b cnt=%0d want 1 1 %0d",
                         c, core_wfi, halt_ifu_req, sleep_cnt, c - 5);
            end
        end
        tmr_irq_r = 1; mtie_r = 1;
        exp_q.push_back(32'd10);
        cyc();
        #1;
        checks++;
        if (core_wfi !== 1'b0 || halt_ifu_req !== 1'b0 || halt_exu_req !== 1'b0) begin
            errs++;
            $display("FAIL wfi_wake: got wfi=%b hi=%b he=%b want 0 0 0",
                     core_wfi, halt_ifu_req, halt_exu_req);
        end
        checks++;
        exp_val = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
        if (sleep_cnt !== exp_val) begin
            errs++;
            $display("FAIL wfi_sleep_cnt: got %0d want %0d", sleep_cnt, exp_val);
        end
        tmr_irq_r = 0; mtie_r = 0; halt_ifu_ack = 0;
    endtask

    task automatic test_masked_wake();
        logic [31:0] exp_cnt;
        exp_cnt = 32'd10;
        cyc(); wfi_req = 1;
        cyc(); wfi_req = 0; halt_ifu_ack = 1; halt_exu_ack = 1;
        cyc(); halt_ifu_ack = 0; halt_exu_ack = 0;
        ext_irq_r = 1; meie_r = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (core_wfi !== 1'b1) begin
                errs++;
                $display("FAIL masked_sleep[%0d]: got core_wfi=%b want 1", i, core_wfi);
            end
            exp_cnt++;
            cyc();
        end
        meie_r = 1;
        exp_cnt++;
        exp_q.push_back(exp_cnt);
        cyc();
        #1;
        checks++;
        if (core_wfi !== 1'b0 || halt_ifu_req !== 1'b0) begin
            errs++;
            $display("FAIL masked_wake: got wfi=%b hi=%b want 0 0", core_wfi, halt_ifu_req);
        end
        checks++;
        exp_val = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
        if (sleep_cnt !== exp_val) begin
            errs++;
            $display("FAIL masked_cnt: got %0d want %0d", sleep_cnt, exp_val);
        end
        ext_irq_r = 0; meie_r = 0;
    endtask

    task automatic test_trap_in_halt();
        cyc(); wfi_req = 1;
        cyc(); wfi_req = 0;
        #1;
        checks++;
        if (halt_ifu_req !== 1'b1) begin
            errs++;
            $display("FAIL halt_trap_pre: got hi=%b want 1", halt_ifu_req);
        end
        trap_req = 1; trap_pc = 32'h8000_0040;
        exp_q.push_back(32'h8000_0040);
        cyc();
        flush_ack = 1; trap_req = 0;
        #1;
        checks++;
        if (halt_ifu_req !== 1'b0 || halt_exu_req !== 1'b0 || flush_req !== 1'b1) begin
            errs++;
            $display("FAIL halt_trap: got hi=%b he=%b req=%b want 0 0 1",
                     halt_ifu_req, halt_exu_req, flush_req);
        end
        if (trap_cmt === 1'b1) pop_flush("halt_trap");
        checks++;
        if (exp_q.size() != 0) begin
            errs++;
            $display("FAIL halt_trap_cmt: got no trap_cmt, want one for 80000040");
        end
        cyc();
        flush_ack = 0;
        exp_q.delete();
    endtask
`else
    task automatic test_wfi_disabled();
        cyc();
        wfi_req = 1; halt_ifu_ack = 1; halt_exu_ack = 1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            wfi_req = 0;
            #1;
            checks++;
            if (halt_ifu_req !== 1'b0 || halt_exu_req !== 1'b0 || core_wfi !== 1'b0 ||
                sleep_cnt !== 32'h0 || flush_req !== 1'b0) begin
                errs++;
                $display("FAIL wfi_disabled[%0d]: got hi=%b he=%b wfi=%b cnt=%0d req=%b want 0",
                         i, halt_ifu_req, halt_exu_req, core_wfi, sleep_cnt, flush_req);
            end
        end
        halt_ifu_ack = 0; halt_exu_ack = 0;
    endtask
`endif

    task automatic test_async_reset();
        cyc();
        trap_req = 1; trap_pc = 32'h8000_0300; flush_ack = 0;
        cyc();
        trap_req = 0;
        #1;
        checks++;
        if (flush_req !== 1'b1 || flush_pc !== 32'h8000_0300) begin
            errs++;
            $display("FAIL areset_pre: got req=%b pc=%h want 1 80000300", flush_req, flush_pc);
        end
        #1 rst_n = 0;
        #1;
        checks++;
        if (flush_req !== 1'b0 || flush_pc !== 32'h0 || trap_cmt !== 1'b0 ||
            halt_ifu_req !== 1'b0 || core_wfi !== 1'b0) begin
            errs++;
            $display("FAIL areset_drop: got req=%b pc=%h cmt=%b hi=%b wfi=%b want all 0",
                     flush_req, flush_pc, trap_cmt, halt_ifu_req, core_wfi);
        end
        flush_ack = 1;
        #1;
        checks++;
        if (trap_cmt !== 1'b0) begin
            errs++;
            $display("FAIL areset_cmt: got trap_cmt=%b want 0", trap_cmt);
        end
        cyc();
        rst_n = 1;
        for (int i = 0; i < 2; i++) begin
            cyc();
            #1;
            checks++;
            if (trap_cmt !== 1'b0 || flush_req !== 1'b0) begin
                errs++;
                $display("FAIL areset_release[%0d]: got cmt=%b req=%b want 0 0",
                         i, trap_cmt, flush_req);
            end
        end
        flush_ack = 0;
    endtask

    initial begin
        errs   = 0;
        checks = 0;
        test_reset();
        test_trap();
        test_back_to_back();
        test_simultaneous();
`ifdef TRAP_SEQ_WFI_EN
        test_wfi();
        test_masked_wake();
        test_trap_in_halt();
`endif
        test_async_reset();
`ifndef TRAP_SEQ_WFI_EN
        test_wfi_disabled();
`endif
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
